// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer and the instruction decoder.
package core_pkg;

    // Sequencer states; encodings are visible on the debug port.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    // Decoded instruction classes produced by the decoder.
    typedef enum logic [3:0] {
        IT_UNKNOWN = 4'b0000,
        IT_R       = 4'b0001,
        IT_LOAD    = 4'b0010,
        IT_IMM     = 4'b0011,
        IT_LUI     = 4'b0100,
        IT_AUIPC   = 4'b0101,
        IT_JAL     = 4'b0110,
        IT_JALR    = 4'b0111,
        IT_BRANCH  = 4'b1000,
        IT_STORE   = 4'b1001
    } instr_type_e;

    // Next-PC source select; 2'b11 is unused.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_JUMP   = 2'b01,
        PC_BRANCH = 2'b10
    } pc_sel_e;

    // Reason recorded when the sequencer enters TRAP.
    typedef enum logic [1:0] {
        TC_ILLEGAL = 2'b00,
        TC_RDWR    = 2'b01,
        TC_IMEM_TO = 2'b10,
        TC_DMEM_TO = 2'b11
    } trap_cause_e;

    // Jump class from the decoder; 2'b11 is reserved.
    typedef enum logic [1:0] {
        JMP_NONE   = 2'b00,
        JMP_JAL    = 2'b01,
        JMP_BRANCH = 2'b10
    } jump_e;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/seq_watchdog.sv
// Request watchdog: counts wait cycles of an outstanding memory request and
// flags the cycle whose increment would bring the count to TIMEOUT.
module seq_watchdog
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    // Clear wins over count so a state change always restarts the window.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle sequencer for the RV32I core: FETCH, DECODE, EXEC, MEM, WB, with
// a sticky TRAP state, a shared request watchdog and a retired-instruction counter.
module core_seq
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    input  logic [3:0]       instr_type,
    input  logic             mem_rd_en,
    input  logic             mem_wd_en,
    input  logic             reg_en,
    input  logic [1:0]       jump,
    input  logic             br_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    state_e            state_q, state_d;
    trap_cause_e       cause_q, cause_d;
    logic              dwe_q, dwe_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              wd_en, wd_clr, wd_expire;

    // The watchdog only runs while a request is outstanding and unanswered.
    assign wd_en  = ((state_q == ST_FETCH) && !imem_ack) || ((state_q == ST_MEM) && !dmem_ack);
    assign wd_clr = (state_d != state_q);

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    // Next-state, trap cause, store qualifier capture and retire count.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        dwe_d     = dwe_q;
        instret_d = instret_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = TC_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (instr_type == IT_UNKNOWN) begin
                    state_d = ST_TRAP;
                    cause_d = TC_ILLEGAL;
                end else if (mem_rd_en && mem_wd_en) begin
                    state_d = ST_TRAP;
                    cause_d = TC_RDWR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (mem_rd_en || mem_wd_en) begin
                    state_d = ST_MEM;
                    // Freeze the write qualifier so it cannot move mid-request.
                    dwe_d   = mem_wd_en;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = TC_DMEM_TO;
                end
            end
            ST_WB: begin
                state_d   = ST_FETCH;
                instret_d = instret_q + CNT_W'(1);
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State registers; reset drops any outstanding request by leaving MEM/FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cause_q   <= TC_ILLEGAL;
            dwe_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            dwe_q     <= dwe_d;
            instret_q <= instret_d;
        end
    end

    // Next-PC source, only meaningful during WB; jumps take priority over branches.
    always_comb begin
        pc_sel = PC_PLUS4;
        if (state_q == ST_WB) begin
            if (jump == JMP_JAL) begin
                pc_sel = PC_JUMP;
            end else if ((jump == JMP_BRANCH) && br_taken) begin
                pc_sel = PC_BRANCH;
            end
        end
    end

    assign imem_req   = (state_q == ST_FETCH);
    assign ir_we      = (state_q == ST_DECODE);
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = (state_q == ST_MEM) && dwe_q;
    assign rf_we      = (state_q == ST_WB) && reg_en && !mem_wd_en;
    assign pc_we      = (state_q == ST_WB);
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;
    assign instret    = instret_q;

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV32I core. It drives instruction fetch, decode settle, execute, data-memory access and writeback, one instruction at a time.
- Consumes the decoded control fields from the instruction decoder: instruction type, mem read/write enables, register write enable, jump class and branch-taken.
- Produces the write strobes for the IR, PC and register file, plus the memory request handshakes.
- Owns the retired-instruction counter and the trap/watchdog logic.

Parameters:
- TIMEOUT, 255, max cycles a memory request may wait for ack before a trap; 8-bit watchdog counter.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request; level, held until ack.
- imem_ack  in  1  fetch data valid this cycle.
- ir_we  out  1  one-cycle pulse that latches the instruction register.
- instr_type  in  4  decoded type: 0001 R, 0010 LOAD, 0011 IMM, 0100 LUI, 0101 AUIPC, 0110 JAL, 0111 JALR, 1000 BRANCH, 1001 STORE, 0000 unknown.
- mem_rd_en  in  1  decoded load.
- mem_wd_en  in  1  decoded store.
- reg_en  in  1  decoded register-file write.
- jump  in  2  00 none, 01 jal/jalr, 10 branch.
- br_taken  in  1  branch comparison result from the ALU; valid in EXEC and WB.
- dmem_req  out  1  data memory request; level, held until ack.
- dmem_we  out  1  write qualifier for dmem_req.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  2  00 pc+4, 01 jump target, 10 branch target.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00 illegal opcode, 01 rd+wr conflict, 10 imem timeout, 11 dmem timeout.
- state_o  out  3  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-request):
  - state=FETCH.
  - All strobes and requests 0; trap=0, trap_cause=00, instret=0, watchdog=0.
  - Outstanding requests are dropped. An ack arriving in the cycle after reset is ignored only if no request is active.
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. All outputs are registered or decoded from state; no combinational path from an ack to a request.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1 for exactly the next cycle, go to DECODE.
  - Otherwise the watchdog increments. When the watchdog reaches TIMEOUT: go to TRAP, cause=10.
- DECODE: one settle cycle.
  - instr_type==0000 -> TRAP, cause=00.
  - mem_rd_en & mem_wd_en -> TRAP, cause=01.
  - Otherwise -> EXEC.
- EXEC: one cycle. Next state is MEM if mem_rd_en | mem_wd_en, else WB.
- MEM:
  - dmem_req=1, dmem_we=mem_wd_en, both stable for the whole request.
  - On dmem_ack: go to WB.
  - Watchdog behaves as in FETCH; timeout gives cause=11.
- WB: single cycle.
  - rf_we = reg_en & ~mem_wd_en.
  - pc_we=1.
  - pc_sel = 01 if jump==01; 10 if jump==10 & br_taken; else 00.
  - instret += 1, wrapping modulo 2^CNT_W.
  - Next state: FETCH.
- TRAP: absorbing. All strobes and requests 0, trap=1, state held until rst.
- Watchdog: clears on every state change. Acks arriving in a non-requesting state are ignored.
- Latency:
  - ALU-type instruction = 4 cycles + fetch wait.
  - Load/store = 5 cycles + fetch wait + data wait.
  - Zero-wait memory (ack in the first request cycle) is supported.

Decomposition:
- Package core_pkg holds:
  - state encodings;
  - instr_type codes (shared with the decoder);
  - pc_sel codes;
  - trap_cause codes;
  - the jump encoding.
- Sub-module seq_watchdog: 8-bit counter with clear/enable inputs, TIMEOUT parameter and an expire output. It is instantiated once and shared by FETCH and MEM.

Test Plan:
- ADD with imem_ack on the first request cycle -> state sequence 0,1,2,4,0; exactly one ir_we pulse; rf_we=1 and pc_we=1 in WB with pc_sel=00; instret=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; rf_we in the following WB; instret increments by 1.
- SW with reg_en forced to 1 -> dmem_we=1 throughout MEM; rf_we=0 in WB.
- BEQ with br_taken=1, then with br_taken=0 -> pc_sel=10, then pc_sel=00. JAL -> pc_sel=01 and rf_we=1.
- instr_type=0000 -> trap=1, cause=00, held for 20 cycles. Then rst=1 for one cycle -> FETCH, trap=0, instret=0.
- imem_ack withheld for 255 cycles -> trap, cause=10. A separate run with rst asserted mid-MEM -> dmem_req drops the next cycle and state=FETCH.
